regfile_wb_arbiter: RTL

Shares the single register-file write port (write enable, write register, write data) between two writeback sources: source 0 (ALU) and source 1 (load/multi-cycle unit). It also keeps a per-register busy scoreboard so the issue stage can stall on RAW/WAW hazards. It sits between the writeback sources and the register file. Its registered write outputs drive the register file's write-enable, write-address and write-data inputs directly, and the register file commits the write on the next rising clock edge.

---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_if.sv | 37 +++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_pkg;
   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NREG = 1 << AW;

   localparam logic [AW-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic            valid;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] wd;
   } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback sources / issue stage and the arbiter.
interface regfile_wb_arbiter_if
   import rf_pkg::*;
   ();
   logic            s0_valid;
   logic            s0_ready;
   logic [AW-1:0]   s0_rd;
   logic [XLEN-1:0] s0_wd;
   logic            s1_valid;
   logic            s1_ready;
   logic [AW-1:0]   s1_rd;
   logic [XLEN-1:0] s1_wd;

   logic            rf_we;
   logic [AW-1:0]   rf_wr;
   logic [XLEN-1:0] rf_wd;

   logic            iss_valid;
   logic [AW-1:0]   iss_rs1;
   logic [AW-1:0]   iss_rs2;
   logic [AW-1:0]   iss_rd;
   logic            iss_we;
   logic            iss_stall;
   logic [NREG-1:0] busy;

   modport master (
      output s0_valid, s0_rd, s0_wd, s1_valid, s1_rd, s1_wd,
      output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_we,
      input  s0_ready, s1_ready, rf_we, rf_wr, rf_wd, iss_stall, busy
   );

   modport slave (
      input  s0_valid, s0_rd, s0_wd, s1_valid, s1_rd, s1_wd,
      input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_we,
      output s0_ready, s1_ready, rf_we, rf_wr, rf_wd, iss_stall, busy
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester arbiter: round-robin on ties when rr_en=1, else requester 0 wins.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rr_en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      gnt = req;
      if (req[0] && req[1]) begin
         gnt = (rr_en && !last_grant_q) ? 2'b10 : 2'b01;
      end
      // History only advances on an actual grant, and only matters in RR mode.
      last_grant_d = last_grant_q;
      if (rr_en && (gnt != 2'b00)) begin
         last_grant_d = gnt[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback sources onto the register-file write port and
// tracks per-register busy bits for issue-stage hazard stalls.
module regfile_wb_arbiter
   import rf_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input logic                 clk,
   input logic                 rst_n,
   regfile_wb_arbiter_if.slave bus
);
   wb_req_t         req0;
   wb_req_t         req1;
   logic [1:0]      gnt;
   logic            xfer;
   logic [AW-1:0]   sel_rd;
   logic [XLEN-1:0] sel_wd;
   logic            iss_stall;
   logic            iss_set;

   logic            rf_we_q, rf_we_d;
   logic [AW-1:0]   rf_wr_q, rf_wr_d;
   logic [XLEN-1:0] rf_wd_q, rf_wd_d;
   logic [NREG-1:0] busy_q, busy_d;

   always_comb begin
      req0 = '{valid: bus.s0_valid, rd: bus.s0_rd, wd: bus.s0_wd};
      req1 = '{valid: bus.s1_valid, rd: bus.s1_rd, wd: bus.s1_wd};
   end

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .rr_en (RR_EN),
      .req   ({req1.valid, req0.valid}),
      .gnt   (gnt)
   );

   assign bus.s0_ready = gnt[0];
   assign bus.s1_ready = gnt[1];

   always_comb begin
      xfer   = |gnt;
      sel_rd = gnt[1] ? req1.rd : req0.rd;
      sel_wd = gnt[1] ? req1.wd : req0.wd;

      // x0 writes still complete the handshake but never reach the regfile.
      rf_we_d = xfer && (sel_rd != ZERO_REG);
      rf_wr_d = xfer ? sel_rd : rf_wr_q;
      rf_wd_d = xfer ? sel_wd : rf_wd_q;
   end

   always_comb begin
      iss_stall = bus.iss_valid &&
                  (busy_q[bus.iss_rs1] || busy_q[bus.iss_rs2] ||
                   (bus.iss_we && busy_q[bus.iss_rd]));
      iss_set   = bus.iss_valid && !iss_stall && bus.iss_we &&
                  (bus.iss_rd != ZERO_REG);

      // Set is applied after clear so a same-cycle collision leaves the bit busy.
      busy_d = busy_q;
      if (rf_we_q) begin
         busy_d[rf_wr_q] = 1'b0;
      end
      if (iss_set) begin
         busy_d[bus.iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q <= 1'b0;
         rf_wr_q <= '0;
         rf_wd_q <= '0;
         busy_q  <= '0;
      end else begin
         rf_we_q <= rf_we_d;
         rf_wr_q <= rf_wr_d;
         rf_wd_q <= rf_wd_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.rf_we     = rf_we_q;
   assign bus.rf_wr     = rf_wr_q;
   assign bus.rf_wd     = rf_wd_q;
   assign bus.busy      = busy_q;
   assign bus.iss_stall = iss_stall;
endmodule
